// File: rtl/rm_step_scheduler.sv
// rtl/rm_step_scheduler.sv - orders multi-lane RVFI retirements into single ISS step requests
// Buffers retirements in program order and hands them out one at a time over a req/ack handshake.
module rm_step_scheduler #(
  parameter int NRET    = 2,
  parameter int DEPTH   = 8,
  parameter int ORDER_W = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NRET-1:0]               ret_valid_i,
  input  logic [NRET*ORDER_W-1:0]       ret_order_i,
  input  logic [NRET-1:0]               ret_halt_i,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic                          resume_i,
  output logic                          step_req_o,
  output logic [ORDER_W-1:0]            step_order_o,
  output logic                          step_halt_o,
  input  logic                          step_ack_i,
  output logic [$clog2(DEPTH):0]        pending_o,
  output logic                          halted_o,
  output logic                          overflow_o,
  output logic                          order_err_o,
  output logic                          late_ret_o,
  output logic [31:0]                   step_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ORDER_W-1:0] ord_mem_q [DEPTH];
  logic [DEPTH-1:0]   halt_mem_q;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      pending_q, pending_d;
  logic               flush_pend_q, flush_pend_d;
  logic               prev_valid_q, prev_valid_d;
  logic [ORDER_W-1:0] prev_order_q, prev_order_d;
  logic               overflow_q, overflow_d;
  logic               order_err_q, order_err_d;
  logic               late_ret_q, late_ret_d;
  logic [31:0]        step_cnt_q, step_cnt_d;

  logic [ORDER_W-1:0] head_order;
  logic               head_halt;
  logic               ack_fire;
  logic               flush_req;
  logic               clear_buf;
  logic               push_ok;
  logic [PW-1:0]      free_slots;
  logic [PW-1:0]      n_push;
  logic               drop;
  logic [NRET-1:0]    lane_we;
  logic [AW-1:0]      lane_idx [NRET];

  assign head_order = ord_mem_q[rd_ptr_q];
  assign head_halt  = halt_mem_q[rd_ptr_q];

  // Buffer bookkeeping: free space is judged against start-of-cycle occupancy only.
  always_comb begin
    ack_fire   = (state_q == S_ISSUE) && step_ack_i;
    flush_req  = flush_i || flush_pend_q;
    clear_buf  = ((state_q == S_IDLE) && flush_i) ||
                 (ack_fire && !head_halt && flush_req) ||
                 ((state_q == S_HALTED) && (flush_i || resume_i));
    push_ok    = (state_q != S_HALTED) && !flush_i && !clear_buf;
    free_slots = PW'(DEPTH) - pending_q;
    n_push     = '0;
    drop       = 1'b0;
    lane_we    = '0;
    for (int k = 0; k < NRET; k++) begin
      lane_idx[k] = wr_ptr_q + AW'(n_push);
      if (ret_valid_i[k] && push_ok) begin
        if (n_push < free_slots) begin
          lane_we[k] = 1'b1;
          n_push     = n_push + PW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q + AW'(ack_fire);
    wr_ptr_d     = wr_ptr_q + AW'(n_push);
    pending_d    = pending_q + n_push - {{(PW-1){1'b0}}, ack_fire};
    if (clear_buf) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      pending_d = '0;
    end
    flush_pend_d = (state_q == S_ISSUE) && !ack_fire && flush_req;
    prev_valid_d = prev_valid_q;
    prev_order_d = prev_order_q;
    order_err_d  = order_err_q;
    step_cnt_d   = step_cnt_q;
    if (ack_fire) begin
      if (prev_valid_q && (head_order != prev_order_q + ORDER_W'(1))) begin
        order_err_d = 1'b1;
      end
      prev_valid_d = 1'b1;
      prev_order_d = head_order;
      step_cnt_d   = step_cnt_q + 32'd1;
    end
    // A resumed run starts a fresh order sequence.
    if ((state_q == S_HALTED) && resume_i) begin
      prev_valid_d = 1'b0;
    end
    overflow_d = overflow_q || drop;
    late_ret_d = late_ret_q || ((state_q == S_HALTED) && (|ret_valid_i));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ord_mem_q[i] <= '0;
      end
      halt_mem_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      pending_q    <= '0;
      flush_pend_q <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_order_q <= '0;
      overflow_q   <= 1'b0;
      order_err_q  <= 1'b0;
      late_ret_q   <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      for (int k = 0; k < NRET; k++) begin
        if (lane_we[k]) begin
          ord_mem_q[lane_idx[k]]  <= ret_order_i[k*ORDER_W +: ORDER_W];
          halt_mem_q[lane_idx[k]] <= ret_halt_i[k];
        end
      end
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pending_q    <= pending_d;
      flush_pend_q <= flush_pend_d;
      prev_valid_q <= prev_valid_d;
      prev_order_q <= prev_order_d;
      overflow_q   <= overflow_d;
      order_err_q  <= order_err_d;
      late_ret_q   <= late_ret_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if ((pending_q != '0) && enable_i && !flush_i) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The request is held until acked regardless of enable or flush.
        if (step_ack_i) begin
          if (head_halt) begin
            state_d = S_HALTED;
          end else if (flush_req) begin
            state_d = S_IDLE;
          end else if ((pending_q > PW'(1)) && enable_i) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALTED: begin
        if (resume_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_req_o   = 1'b0;
    step_order_o = '0;
    step_halt_o  = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      S_ISSUE: begin
        step_req_o   = 1'b1;
        step_order_o = head_order;
        step_halt_o  = head_halt;
      end
      S_HALTED: halted_o = 1'b1;
      default: ;
    endcase
  end

  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;
  assign order_err_o = order_err_q;
  assign late_ret_o  = late_ret_q;
  assign step_cnt_o  = step_cnt_q;

endmodule
